crc_generator: RTL and testbench
================================

# crc_generator

Serial CRC-8 generator for bit-streamed data. It shifts one data bit per clock into a linear-feedback register while `data_valid` is high, and presents the running CRC on a registered output. It sits at the tail of a serial transmit or check path, and the downstream logic samples `crc_out` after the last message bit.

## Interface
Parameters:
- `WIDTH`, default 8: CRC register width in bits.
- `POLY`, default 8'h07: generator polynomial, x^8+x^2+x+1; the implicit top term is omitted.
- `INIT`, default 8'h00: register value after reset.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: asynchronous, active-low reset.
- `data_valid`  input  1: high means `data_in` is a message bit this cycle.
- `data_in`  input  1: serial message bit, MSB-first.
- `crc_out`  output  WIDTH: running CRC register value.

## Operation
- State is one WIDTH-bit register `crc`, and `crc_out` = `crc` directly, with no combinational path from inputs.
- When `rst`=0: `crc` ← INIT immediately, independent of `clk`.
- On a rising `clk` with `rst`=1 and `data_valid`=1:
  - fb = `crc`[WIDTH-1] XOR `data_in`.
  - `crc` ← {`crc`[WIDTH-2:0], 1'b0} XOR (fb ? POLY : 0).
- On a rising `clk` with `data_valid`=0: `crc` holds.
- There is no augmentation, no final XOR and no bit reflection. After N valid bits, `crc_out` equals CRC-8/SMBus of the message (init 0).
- There is no per-message clear input. A new message requires reset to be asserted, or the consumer tracks continuation.
- `data_in` is ignored when `data_valid`=0. X on `data_in` with `data_valid`=0 must not propagate into `crc`.

## Timing
- Reset value: `crc_out` = INIT (8'h00).
- Latency: one cycle. A bit sampled at edge k is reflected in `crc_out` immediately after edge k.
- Throughput: one bit per cycle and no stall. `data_valid` can toggle on any cycle, and gaps are allowed without affecting the result.
- Reset mid-message: the partial CRC is discarded and `crc_out` = INIT. The first valid bit after release starts a new message.
- Deassertion of `rst` is expected synchronous to `clk` externally; no internal synchronizer is required.

## Structure
- Shared package `crc_pkg`:
  - constant `CRC8_POLY` = 8'h07;
  - constant `CRC8_INIT` = 8'h00;
  - function `crc_step(crc, bit, poly)` returning the next register value.
- One natural sub-module `crc_lfsr_step`: combinational single-bit update (crc_in, bit_in → crc_next), parameterized by WIDTH/POLY. The top module holds the register, enable and reset around it.
- Optional extension kept within scope: a generate loop chaining `crc_lfsr_step` instances for a parallel data width. The default configuration remains serial, 1 bit.

## Test plan
- Reset: assert `rst`=0 with `data_valid`=1 and toggling `data_in` → `crc_out`=8'h00 throughout; the value holds after release until the first valid edge.
- Byte 8'hB3, MSB-first: bits 1,0,1,1,0,0,1,1 with `data_valid`=1 for 8 cycles.
  - Per-edge `crc_out`: 07, 0E, 1B, 31, 62, C4, 88, 10.
  - After `data_valid`=0, `crc_out` holds 8'h10 for 5+ cycles.
- Single bit 1 after reset → 8'h07. Byte 8'h01 → 8'h07. Byte 8'hFF → 8'hF3.
- Gaps: byte 8'hB3 with `data_valid` low for 1–3 random cycles between bits and `data_in` randomized during gaps → final 8'h10.
- Reset mid-message: after 4 bits of 8'hB3 (`crc_out`=8'h31), pulse `rst` low → 8'h00 asynchronously. Then full byte 8'hFF → 8'hF3.
- Random regression: 1000 random messages of 1–64 bits, compared against a reference model of CRC-8 poly 0x07, init 0, no reflection, no final XOR.

Source files
------------

// File: rtl/crc_pkg.sv
// crc_pkg -- shared CRC-8 constants and a reference single-bit update (rev 1.0)
`default_nettype none

package crc_pkg;

  localparam int         CRC8_WIDTH = 8;
  localparam logic [7:0] CRC8_POLY  = 8'h07;
  localparam logic [7:0] CRC8_INIT  = 8'h00;

  // Non-augmented MSB-first update: the message bit enters at the feedback tap.
  function automatic logic [7:0] crc_step(
    input logic [7:0] crc,
    input logic       bit_in,
    input logic [7:0] poly
  );
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/crc_lfsr_step.sv
// crc_lfsr_step -- combinational one-bit LFSR update for a WIDTH-bit CRC (rev 1.0)
`default_nettype none

module crc_lfsr_step
  import crc_pkg::*;
#(
  parameter int               WIDTH = CRC8_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(CRC8_POLY)
) (
  input  logic [WIDTH-1:0] crc_in,
  input  logic             bit_in,
  output logic [WIDTH-1:0] crc_next
);

  logic fb;

  always_comb begin
    fb       = crc_in[WIDTH-1] ^ bit_in;
    crc_next = {crc_in[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

endmodule

`default_nettype wire

// File: rtl/crc_generator.sv
// crc_generator -- running CRC register built around a chain of crc_lfsr_step (rev 1.0)
`default_nettype none

module crc_generator
  import crc_pkg::*;
#(
  parameter int               WIDTH  = CRC8_WIDTH,
  parameter logic [WIDTH-1:0] POLY   = WIDTH'(CRC8_POLY),
  parameter logic [WIDTH-1:0] INIT   = WIDTH'(CRC8_INIT),
  parameter int               DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic [WIDTH-1:0]  crc_out
);

  logic [WIDTH-1:0] chain [DATA_W+1];
  logic [WIDTH-1:0] crc_d;
  logic [WIDTH-1:0] crc_q;

  assign chain[0] = crc_q;

  // Parallel words are consumed MSB-first, matching the serial bit order.
  for (genvar i = 0; i < DATA_W; i++) begin : g_step
    crc_lfsr_step #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
    ) u_step (
      .crc_in   (chain[i]),
      .bit_in   (data_in[DATA_W-1-i]),
      .crc_next (chain[i+1])
    );
  end

  always_comb begin
    crc_d = crc_q;
    if (data_valid) begin
      crc_d = chain[DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_q <= INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_out = crc_q;

endmodule

`default_nettype wire

// File: tb/tb_crc_generator.sv
// tb_crc_generator -- table vectors plus scoreboarded bit stream against a long-division CRC-8 model
`default_nettype none

module tb_crc_generator;

  logic       clk;
  logic       rst;
  logic       data_valid;
  logic       data_in;
  logic [7:0] crc_out;

  int n_cmp;
  int n_bad;

  logic [7:0]  exp_q [$];
  logic [7:0]  last_exp;
  logic [63:0] msg;
  int          msg_n;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs [4];
  logic [7:0] b3_edges [8];

  crc_generator dut (
    .clk        (clk),
    .rst        (rst),
    .data_valid (data_valid),
    .data_in    (data_in),
    .crc_out    (crc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: remainder of M(x)*x^8 divided by x^8+x^2+x+1 (augmented long division).
  function automatic logic [7:0] crc_ref(input logic [63:0] m, input int n);
    logic [8:0] rem;
    rem = '0;
    for (int i = n - 1; i >= 0; i--) begin
      rem = {rem[7:0], m[i]};
      if (rem[8]) rem = rem ^ 9'h107;
    end
    for (int i = 0; i < 8; i++) begin
      rem = {rem[7:0], 1'b0};
      if (rem[8]) rem = rem ^ 9'h107;
    end
    return rem[7:0];
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: crc_out=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b0;
    data_valid = 1'b0;
    @(negedge clk);
    rst   = 1'b1;
    msg   = '0;
    msg_n = 0;
    last_exp = 8'h00;
    #1 check("reset", crc_out, 8'h00);
  endtask

  task automatic send_bit(input logic b);
    logic [7:0] e;
    @(negedge clk);
    data_valid = 1'b1;
    data_in    = b;
    msg        = {msg[62:0], b};
    msg_n      = msg_n + 1;
    exp_q.push_back(crc_ref(msg, msg_n));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: queue empty, crc_out=%h", crc_out);
    end else begin
      e = exp_q.pop_front();
      last_exp = e;
      check("bit", crc_out, e);
    end
  endtask

  task automatic gap(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      data_valid = 1'b0;
      data_in    = 1'($urandom);
      @(posedge clk);
      #1 check("hold", crc_out, last_exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
  endtask

  initial begin
    logic [7:0] b3;
    int         len;
    n_cmp      = 0;
    n_bad      = 0;
    msg        = '0;
    msg_n      = 0;
    last_exp   = 8'h00;
    rst        = 1'b0;
    data_valid = 1'b0;
    data_in    = 1'b0;

    vecs[0] = '{data: 8'hB3, exp: 8'h10};
    vecs[1] = '{data: 8'h01, exp: 8'h07};
    vecs[2] = '{data: 8'hFF, exp: 8'hF3};
    vecs[3] = '{data: 8'h00, exp: 8'h00};
    b3_edges = '{8'h07, 8'h0E, 8'h1B, 8'h31, 8'h62, 8'hC4, 8'h88, 8'h10};
    b3 = 8'hB3;

    // Reset held with valid data toggling, then idle after release.
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      data_valid = 1'b1;
      data_in    = 1'(i);
      @(posedge clk);
      #1 check("in_reset", crc_out, 8'h00);
    end
    @(negedge clk);
    data_valid = 1'b0;
    rst        = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check("post_release", crc_out, 8'h00);
    end

    // Per-edge trace of 0xB3 then a hold window.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_bit(b3[7-i]);
      check("b3_edge", crc_out, b3_edges[i]);
    end
    gap(6);

    // Table of whole bytes.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      send_byte(vecs[v].data);
      check("byte", crc_out, vecs[v].exp);
    end

    // Single bit after reset.
    do_reset();
    send_bit(1'b1);
    check("single_bit", crc_out, 8'h07);

    // 0xB3 with random gaps between bits.
    do_reset();
    for (int i = 7; i >= 0; i--) begin
      send_bit(b3[i]);
      if (i != 0) gap(int'($urandom_range(1, 3)));
    end
    check("gapped_b3", crc_out, 8'h10);

    // Asynchronous reset mid-message, then a fresh message.
    do_reset();
    for (int i = 7; i >= 4; i--) send_bit(b3[i]);
    check("mid_partial", crc_out, 8'h31);
    @(negedge clk);
    data_valid = 1'b0;
    #2 rst = 1'b0;
    #1 check("async_reset", crc_out, 8'h00);
    @(negedge clk);
    rst   = 1'b1;
    msg   = '0;
    msg_n = 0;
    send_byte(8'hFF);
    check("after_mid_reset", crc_out, 8'hF3);

    // Random regression.
    for (int m = 0; m < 1000; m++) begin
      do_reset();
      len = int'($urandom_range(1, 64));
      for (int i = 0; i < len; i++) begin
        send_bit(1'($urandom));
        if ($urandom_range(0, 7) == 0) gap(1);
      end
    end

    @(negedge clk);
    data_valid = 1'b0;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
